fetch_stage: RTL and testbench



---
 rtl/fetch_stage_pkg.sv | 30 +++
 rtl/fetch_stage_if.sv | 12 +
 rtl/fetch_next_pc.sv | 39 +++
 rtl/fetch_stage.sv | 130 +++++++++++++
 tb/tb_fetch_stage.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the IF stage: constants, FSM states and the
// redirect-select encoding also used by the control unit.
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTRUCTION  = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    REDIR_NONE = 2'd0,
    REDIR_JR   = 2'd1,
    REDIR_J    = 2'd2,
    REDIR_BR   = 2'd3
  } redirect_sel_t;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_HOLD  = 1'b1
  } fetch_state_t;

  // jr beats j beats taken branch when several arrive together
  function automatic redirect_sel_t redirect_select(input logic jr,
                                                    input logic j,
                                                    input logic br);
    if (jr)      return REDIR_JR;
    else if (j)  return REDIR_J;
    else if (br) return REDIR_BR;
    else         return REDIR_NONE;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/ready bus between the fetch stage and imem.
interface fetch_stage_if;
  logic        imemRequest;
  logic [31:0] imemAddress;
  logic        imemReady;
  logic [31:0] imemData;

  modport master (output imemRequest, output imemAddress,
                  input  imemReady,   input  imemData);
  modport slave  (input  imemRequest, input  imemAddress,
                  output imemReady,   output imemData);
endinterface

// File: rtl/fetch_next_pc.sv
// Next-pc selection: redirect target priority, pending target and pc+4.
module fetch_next_pc
  import fetch_stage_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic        i_shouldStall,
  input  logic        i_isBranch,
  input  logic [31:0] i_branchTarget,
  input  logic        i_isJump,
  input  logic [31:0] i_jumpTarget,
  input  logic        i_isJumpRegister,
  input  logic [31:0] i_registerTarget,
  input  logic        i_pendingValid,
  input  logic [31:0] i_pendingTarget,
  output logic        o_redirect,
  output logic [31:0] o_target,
  output logic [31:0] o_pcPlus4,
  output logic [31:0] o_nextOnAccept,
  output logic [31:0] o_nextOnStall
);

  redirect_sel_t w_sel;

  // Priority mux of redirect sources and the candidate next pcs
  always_comb begin
    w_sel = redirect_select(i_isJumpRegister, i_isJump, i_isBranch);
    case (w_sel)
      REDIR_JR: o_target = i_registerTarget;
      REDIR_J:  o_target = i_jumpTarget;
      REDIR_BR: o_target = i_branchTarget;
      default:  o_target = '0;
    endcase
    o_redirect     = (w_sel != REDIR_NONE) && !i_shouldStall;
    o_pcPlus4      = i_pc + 32'd4;
    o_nextOnStall  = i_pendingValid ? i_pendingTarget : o_pcPlus4;
    o_nextOnAccept = o_redirect ? o_target : o_nextOnStall;
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS IF stage: owns the pc, fetches over the imem handshake, buffers a
// word while decode stalls, applies delayed-slot redirects, drives IF/ID.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               shouldStall,
  input  logic               isBranch,
  input  logic [31:0]        branchTarget,
  input  logic               isJump,
  input  logic [31:0]        jumpTarget,
  input  logic               isJumpRegister,
  input  logic [31:0]        registerTarget,
  fetch_stage_if.master      imem,
  output logic [31:0]        ifInstruction,
  output logic [31:0]        idInstruction,
  output logic [31:0]        idPcPlus4,
  output logic               idValid
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic         r_pendingValid;
  logic [31:0]  r_pendingTarget;
  logic [31:0]  r_bufWord;
  logic [31:0]  r_bufPc;
  logic [31:0]  r_idInstruction;
  logic [31:0]  r_idPcPlus4;
  logic         r_idValid;

  logic         w_redirect;
  logic [31:0]  w_target;
  logic [31:0]  w_pcPlus4;
  logic [31:0]  w_nextOnAccept;
  logic [31:0]  w_nextOnStall;

  fetch_next_pc u_next_pc (
    .i_pc             (r_pc),
    .i_shouldStall    (shouldStall),
    .i_isBranch       (isBranch),
    .i_branchTarget   (branchTarget),
    .i_isJump         (isJump),
    .i_jumpTarget     (jumpTarget),
    .i_isJumpRegister (isJumpRegister),
    .i_registerTarget (registerTarget),
    .i_pendingValid   (r_pendingValid),
    .i_pendingTarget  (r_pendingTarget),
    .o_redirect       (w_redirect),
    .o_target         (w_target),
    .o_pcPlus4        (w_pcPlus4),
    .o_nextOnAccept   (w_nextOnAccept),
    .o_nextOnStall    (w_nextOnStall)
  );

  // FETCH/HOLD state machine with pc, pending redirect, buffer and IF/ID
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state         <= ST_FETCH;
      r_pc            <= RESET_PC;
      r_pendingValid  <= 1'b0;
      r_pendingTarget <= '0;
      r_bufWord       <= '0;
      r_bufPc         <= '0;
      r_idInstruction <= NOP_INSTRUCTION;
      r_idPcPlus4     <= '0;
      r_idValid       <= 1'b0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (imem.imemReady) begin
            r_pendingValid <= 1'b0;
            if (!shouldStall) begin
              r_idInstruction <= imem.imemData;
              r_idPcPlus4     <= w_pcPlus4;
              r_idValid       <= 1'b1;
              r_pc            <= w_nextOnAccept;
            end else begin
              // pc advances now so HOLD only has to override it on a redirect
              r_bufWord <= imem.imemData;
              r_bufPc   <= r_pc;
              r_pc      <= w_nextOnStall;
              r_state   <= ST_HOLD;
            end
          end else begin
            if (!shouldStall) begin
              r_idInstruction <= NOP_INSTRUCTION;
              r_idValid       <= 1'b0;
            end
            // outstanding fetch is the delay slot; target applies after it
            if (w_redirect) begin
              r_pendingTarget <= w_target;
              r_pendingValid  <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (!shouldStall) begin
            r_idInstruction <= r_bufWord;
            r_idPcPlus4     <= r_bufPc + 32'd4;
            r_idValid       <= 1'b1;
            r_state         <= ST_FETCH;
            if (w_redirect) r_pc <= w_target;
          end
        end
        default: r_state <= ST_FETCH;
      endcase
    end
  end

  // Request is suppressed during reset so it rises the cycle after release
  always_comb begin
    imem.imemRequest = (r_state == ST_FETCH) && !reset;
    imem.imemAddress = {r_pc[31:2], 2'b00};
  end

  // Word currently in IF, used by the control unit for look-ahead
  always_comb begin
    ifInstruction = NOP_INSTRUCTION;
    if (r_state == ST_HOLD)      ifInstruction = r_bufWord;
    else if (imem.imemReady)     ifInstruction = imem.imemData;
  end

  assign idInstruction = r_idInstruction;
  assign idPcPlus4     = r_idPcPlus4;
  assign idValid       = r_idValid;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: the model is the architectural stream of
// delivered instruction addresses (sequential, with the word after a delay
// slot replaced by the redirect target); a monitor pops it on each delivery.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        shouldStall = 1'b0;
  logic        isBranch = 1'b0, isJump = 1'b0, isJumpRegister = 1'b0;
  logic [31:0] branchTarget = '0, jumpTarget = '0, registerTarget = '0;
  logic [31:0] ifInstruction, idInstruction, idPcPlus4;
  logic        idValid;

  fetch_stage_if bus();

  int total = 0;
  int bad = 0;
  int delivered = 0;
  logic [31:0] exp_q[$];

  always #5 clock = ~clock;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, a[31:16]} + 32'h1357_9BDF;
  endfunction

  // Memory contents are a fixed function of the address
  assign bus.imemData = word_at(bus.imemAddress);

  fetch_stage #(.RESET_PC(RPC)) dut (
    .clock          (clock),
    .reset          (reset),
    .shouldStall    (shouldStall),
    .isBranch       (isBranch),
    .branchTarget   (branchTarget),
    .isJump         (isJump),
    .jumpTarget     (jumpTarget),
    .isJumpRegister (isJumpRegister),
    .registerTarget (registerTarget),
    .imem           (bus),
    .ifInstruction  (ifInstruction),
    .idInstruction  (idInstruction),
    .idPcPlus4      (idPcPlus4),
    .idValid        (idValid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    if ($urandom_range(9) == 0) t = 32'hFFFF_FFF0 + 32'(4 * $urandom_range(3));
    else                        t = $urandom() & 32'hFFFF_FFFC;
    return t;
  endfunction

  // Monitor: on every IF/ID update that delivers a real instruction, pop
  initial begin
    logic rs, st;
    logic [31:0] a;
    forever begin
      @(posedge clock);
      rs = reset;
      st = shouldStall;
      #1;
      if (!rs) begin
        if (!st && idValid === 1'b1) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL delivery: got %h expected none queued", idPcPlus4);
          end else begin
            a = exp_q.pop_front();
            chk("id_instr", idInstruction, word_at(a));
            chk("id_pc4", idPcPlus4, a + 32'd4);
            delivered++;
            if (exp_q.size() < 2) exp_q.push_back(exp_q[$] + 32'd4);
          end
        end else if (idValid !== 1'b1) begin
          chk("bubble_instr", idInstruction, NOP_INSTRUCTION);
        end
      end
    end
  end

  // Stimulus
  initial begin
    logic        req, rdy, stall, prevReq, prevRdy;
    logic [31:0] prevAddr, tgt;
    logic [2:0]  fl;
    int          rdyPct, stallPct;
    int          rdyTab[5]   = '{100, 33, 50, 80, 20};
    int          stallTab[5] = '{0, 20, 30, 10, 40};

    exp_q = {RPC, RPC + 32'd4};
    bus.imemReady = 1'b0;
    prevReq = 1'b0; prevRdy = 1'b0; prevAddr = '0;

    repeat (3) @(negedge clock);
    chk("rst_req", 32'(bus.imemRequest), 32'd0);
    chk("rst_idValid", 32'(idValid), 32'd0);
    chk("rst_idInstr", idInstruction, NOP_INSTRUCTION);
    chk("rst_idPc4", idPcPlus4, 32'd0);

    // Zero-wait memory, no stalls: one new address every cycle
    reset = 1'b0;
    bus.imemReady = 1'b1;
    for (int k = 0; k < 16; k++) begin
      #1;
      chk("zw_req", 32'(bus.imemRequest), 32'd1);
      chk("zw_addr", bus.imemAddress, RPC + 32'(4 * k));
      @(negedge clock);
    end

    // Hold the 0x40 fetch outstanding, then reset with a late ready
    bus.imemReady = 1'b0;
    @(negedge clock);
    chk("pre_rst_addr", bus.imemAddress, RPC + 32'h40);
    reset = 1'b1;
    bus.imemReady = 1'b1;
    exp_q = {RPC, RPC + 32'd4};
    @(posedge clock);
    #1;
    chk("midrst_idValid", 32'(idValid), 32'd0);
    chk("midrst_idInstr", idInstruction, NOP_INSTRUCTION);
    chk("midrst_req", 32'(bus.imemRequest), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    bus.imemReady = 1'b0;
    #1;
    chk("post_rst_req", 32'(bus.imemRequest), 32'd1);
    chk("post_rst_addr", bus.imemAddress, RPC);
    @(negedge clock);

    // Randomized traffic: wait states, stalls, redirects
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rdyPct   = rdyTab[(cyc / 600) % 5];
      stallPct = stallTab[(cyc / 600) % 5];
      req = bus.imemRequest;
      if (prevReq && !prevRdy && req) chk("addr_hold", bus.imemAddress, prevAddr);
      if (!req) chk("hold_ifinstr", ifInstruction, word_at(exp_q[0]));

      stall = ($urandom_range(99) < stallPct);
      rdy   = req && ($urandom_range(99) < rdyPct);

      isBranch = 1'b0; isJump = 1'b0; isJumpRegister = 1'b0;
      branchTarget = rand_target();
      jumpTarget = rand_target();
      registerTarget = rand_target();
      if (idValid === 1'b1 && !stall && $urandom_range(99) < 25) begin
        fl = 3'($urandom_range(7, 1));
        {isJumpRegister, isJump, isBranch} = fl;
        tgt = isJumpRegister ? registerTarget : isJump ? jumpTarget : branchTarget;
        // the word after the delay slot becomes the target
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        exp_q.push_back(tgt);
      end else if (stall && $urandom_range(99) < 30) begin
        fl = 3'($urandom_range(7, 1));
        {isJumpRegister, isJump, isBranch} = fl;
      end

      shouldStall = stall;
      bus.imemReady = rdy;
      prevReq = req;
      prevRdy = rdy;
      prevAddr = bus.imemAddress;
      #1;
      if (rdy) chk("if_accept", ifInstruction, word_at(bus.imemAddress));
      @(negedge clock);
    end

    shouldStall = 1'b0;
    bus.imemReady = 1'b0;
    isBranch = 1'b0; isJump = 1'b0; isJumpRegister = 1'b0;
    chk("progress", 32'(delivered > 500), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
